inst_fetch: RTL and testbench

//  Instruction-fetch stage sitting directly upstream of mem_ctrl: owns the PC, looks it up in a

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_icache_array.sv | 47 ++++
 rtl/inst_fetch.sv | 152 +++++++++++++++
 tb/tb_inst_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, constants, helpers.
// Build option ICACHE_EN (see inst_fetch.sv) selects the full direct-mapped cache.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int INST_WIDTH       = 32;
    localparam int DEFAULT_RESET_PC = 0;

    localparam logic [INST_WIDTH-1:0] ZERO = '0;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/inst_fetch_icache_array.sv
// Instruction cache storage: valid/tag/data per line, combinational read by index,
// single write port; rst clears every valid bit.
module icache_array
    import inst_fetch_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [INST_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [INST_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]      valid;
    logic [TAG_W-1:0]      tags  [DEPTH];
    logic [INST_WIDTH-1:0] words [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= TRUE;
        end
    end

    // Tag/data need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = words[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, cache lookup, miss handshake to mem_ctrl, IF/ID outputs.
// ICACHE_EN defined: ICACHE_LINES-line direct-mapped cache; undefined: single full-tag entry.
//
// state | meaning
// IDLE  | look up pc; deliver on hit, start a miss otherwise
// REQ   | mem_inst_req high, waiting for mem_ctrl to accept (done seen low)
// WAIT  | request accepted, waiting for done to fill the cache
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    ICACHE_LINES = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  id_stall_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  inst_valid_o,
    output logic                  mem_inst_req,
    output logic [ADDR_WIDTH-1:0] mem_inst_addr,
    input  logic [INST_WIDTH-1:0] mem_inst_data,
    input  logic                  mem_inst_done
);

    if (!is_pow2(ICACHE_LINES)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two");
    end

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
`else
    localparam int IDX_W = 1;
    localparam int TAG_W = ADDR_WIDTH - 2;
`endif

    fetch_state_e state, state_n;

    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [ADDR_WIDTH-1:0] pc_o_n;
    logic                  valid_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  fill;

    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic [TAG_W-1:0]      rd_tag, wr_tag, line_tag;
    logic                  line_valid;
    logic [INST_WIDTH-1:0] line_data;
    logic                  hit;

`ifdef ICACHE_EN
    assign rd_idx = pc[2 +: IDX_W];
    assign rd_tag = pc[ADDR_WIDTH-1 -: TAG_W];
    assign wr_idx = mem_inst_addr[2 +: IDX_W];
    assign wr_tag = mem_inst_addr[ADDR_WIDTH-1 -: TAG_W];
`else
    assign rd_idx = '0;
    assign rd_tag = pc[ADDR_WIDTH-1:2];
    assign wr_idx = '0;
    assign wr_tag = mem_inst_addr[ADDR_WIDTH-1:2];
`endif

    icache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fill),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (mem_inst_data),
        .rd_idx   (rd_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    assign hit          = line_valid && (line_tag == rd_tag);
    assign mem_inst_req = (state == REQ);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst_o;
        pc_o_n  = pc_o;
        valid_n = inst_valid_o;
        addr_n  = mem_inst_addr;
        fill    = FALSE;

        unique case (state)
            IDLE: begin
                // A jump here must not launch a miss for the pc it is replacing.
                if (!jump_i && !(id_stall_i && inst_valid_o)) begin
                    if (hit) begin
                        inst_n  = line_data;
                        pc_o_n  = pc;
                        valid_n = TRUE;
                        pc_n    = pc + ADDR_WIDTH'(4);
                    end else begin
                        valid_n = FALSE;
                        addr_n  = pc;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                // done is also high while mem_ctrl is idle, so only a low sample means accepted.
                if (!mem_inst_done) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mem_inst_done) begin
                    fill    = TRUE;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // In-flight misses still finish and fill; only the pc and delivery are redirected.
        if (jump_i) begin
            pc_n    = jump_addr_i;
            valid_n = FALSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            inst_o        <= ZERO;
            pc_o          <= '0;
            inst_valid_o  <= FALSE;
            mem_inst_addr <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            inst_o        <= inst_n;
            pc_o          <= pc_o_n;
            inst_valid_o  <= valid_n;
            mem_inst_addr <= addr_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: mem_ctrl model plus a line-address cache model; id_stall_i is
// held high so each delivery freezes and the bench steps the fetcher one word at a time.
module tb_inst_fetch;

`ifdef ICACHE_EN
    localparam int MODEL_LINES = 64;
`else
    localparam int MODEL_LINES = 1;
`endif

    logic        clk;
    logic        rst;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        id_stall_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;
    logic        mem_inst_req;
    logic [31:0] mem_inst_addr;
    logic [31:0] mem_inst_data;
    logic        mem_inst_done;

    inst_fetch #(
        .ADDR_WIDTH   (32),
        .ICACHE_LINES (64),
        .RESET_PC     (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .id_stall_i    (id_stall_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .inst_valid_o  (inst_valid_o),
        .mem_inst_req  (mem_inst_req),
        .mem_inst_addr (mem_inst_addr),
        .mem_inst_data (mem_inst_data),
        .mem_inst_done (mem_inst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          req_count = 0;
    int          busy = 0;
    logic        block_mem = 1'b0;
    logic [31:0] last_req_addr = 32'h0;

    logic [29:0] m_tag [MODEL_LINES];
    bit          m_v   [MODEL_LINES];
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // mem_ctrl: done drops the cycle after a request is accepted, stays low 5 cycles.
    initial begin
        mem_inst_done = 1'b1;
        mem_inst_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy = 0;
                mem_inst_done = 1'b1;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    mem_inst_done = 1'b1;
                    mem_inst_data = mem_word(last_req_addr);
                end
            end else if (mem_inst_req && !block_mem) begin
                busy = 5;
                mem_inst_done = 1'b0;
                last_req_addr = mem_inst_addr;
                req_count++;
            end
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < MODEL_LINES; i++) m_v[i] = 1'b0;
    endfunction

    // Returns 1 when the word at a is not cached (a memory fetch is due) and caches it.
    function automatic int model_fetch(input logic [31:0] a);
        int i;
        i = int'(a[31:2] % 30'(MODEL_LINES));
        if (m_v[i] && m_tag[i] == a[31:2]) return 0;
        m_v[i] = 1'b1;
        m_tag[i] = a[31:2];
        return 1;
    endfunction

    task automatic do_advance();
        id_stall_i = 1'b0;
        @(negedge clk);
        id_stall_i = 1'b1;
    endtask

    task automatic do_jump(input logic [31:0] a);
        jump_i = 1'b1;
        jump_addr_i = a;
        @(negedge clk);
        jump_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid_o); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", inst_o); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", pc_o); end
        total++; if (mem_inst_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_inst_addr); end
        total++; if (mem_inst_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_inst_req); end
        model_clear();
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        int r0;
        bit ok;
        r0 = req_count;
        exp_pc = 32'h0;
        void'(model_fetch(exp_pc));
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL first_timeout got=no_valid want=valid"); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL first_pc got=%h want=0", pc_o); end
        total++; if (inst_o !== 32'h0000_0013) begin bad++; $display("FAIL first_inst got=%h want=00000013", inst_o); end
        total++; if (req_count - r0 !== 1) begin bad++; $display("FAIL first_reqs got=%0d want=1", req_count - r0); end
        total++; if (last_req_addr !== 32'h0) begin bad++; $display("FAIL first_req_addr got=%h want=0", last_req_addr); end
    endtask

    task automatic test_jump_hit();
        int r0, nmiss, cyc;
        bit ok;
        r0 = req_count;
        exp_pc = 32'h4;
        nmiss = model_fetch(exp_pc);
        do_advance();
        wait_valid(ok);
        total++; if (!ok || pc_o !== 32'h4) begin bad++; $display("FAIL jh_pc4 got=%h want=4", pc_o); end
        total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL jh_reqs4 got=%0d want=%0d", req_count - r0, nmiss); end
        r0 = req_count;
        exp_pc = 32'h0;
        nmiss = model_fetch(exp_pc);
        do_jump(exp_pc);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL jh_valid_drop got=%b want=0", inst_valid_o); end
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin cyc = i; break; end
        end
        if (nmiss == 0) begin
            total++; if (cyc !== 1) begin bad++; $display("FAIL jh_latency got=%0d want=1", cyc); end
        end
        total++; if (cyc == 0 || pc_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin bad++; $display("FAIL jh_pc0 got=%h/%h want=0/%h", pc_o, inst_o, mem_word(32'h0)); end
        total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL jh_reqs0 got=%0d want=%0d", req_count - r0, nmiss); end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [2] = '{32'h100, 32'h000};
        int r0, nmiss;
        bit ok;
        foreach (seq[k]) begin
            r0 = req_count;
            exp_pc = seq[k];
            nmiss = model_fetch(exp_pc);
            do_jump(exp_pc);
            wait_valid(ok);
            total++; if (!ok || pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin bad++; $display("FAIL conflict_out got=%h/%h want=%h/%h", pc_o, inst_o, exp_pc, mem_word(exp_pc)); end
            total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL conflict_reqs pc=%h got=%0d want=%0d", exp_pc, req_count - r0, nmiss); end
        end
    endtask

    task automatic test_jump_in_wait();
        int r0, nmiss;
        bit ok;
        exp_pc = 32'h4;
        void'(model_fetch(exp_pc));
        do_advance();
        wait_valid(ok);
        r0 = req_count;
        nmiss = model_fetch(32'h8);
        do_advance();
        @(negedge clk);
        total++; if (mem_inst_req !== 1'b0 || mem_inst_addr !== 32'h8) begin bad++; $display("FAIL jw_wait got=%b/%h want=0/00000008", mem_inst_req, mem_inst_addr); end
        exp_pc = 32'h40;
        nmiss += model_fetch(exp_pc);
        do_jump(exp_pc);
        wait_valid(ok);
        total++; if (!ok || pc_o !== 32'h40 || inst_o !== mem_word(32'h40)) begin bad++; $display("FAIL jw_next got=%h/%h want=00000040/%h", pc_o, inst_o, mem_word(32'h40)); end
        total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL jw_reqs got=%0d want=%0d", req_count - r0, nmiss); end
        r0 = req_count;
        exp_pc = 32'h8;
        nmiss = model_fetch(exp_pc);
        do_jump(exp_pc);
        wait_valid(ok);
        total++; if (!ok || pc_o !== 32'h8 || inst_o !== mem_word(32'h8)) begin bad++; $display("FAIL jw_refetch got=%h/%h want=00000008/%h", pc_o, inst_o, mem_word(32'h8)); end
        total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL jw_cached got=%0d want=%0d", req_count - r0, nmiss); end
    endtask

    task automatic test_stall();
        int r0, nmiss;
        bit ok;
        r0 = req_count;
        repeat (3) begin
            @(negedge clk);
            total++; if (inst_valid_o !== 1'b1 || pc_o !== exp_pc || inst_o !== mem_word(exp_pc) || mem_inst_req !== 1'b0) begin
                bad++; $display("FAIL stall_hold got=%b/%h/%h/%b want=1/%h/%h/0", inst_valid_o, pc_o, inst_o, mem_inst_req, exp_pc, mem_word(exp_pc));
            end
        end
        total++; if (req_count - r0 !== 0) begin bad++; $display("FAIL stall_reqs got=%0d want=0", req_count - r0); end
        exp_pc = exp_pc + 32'h4;
        nmiss = model_fetch(exp_pc);
        do_advance();
        wait_valid(ok);
        total++; if (!ok || pc_o !== exp_pc) begin bad++; $display("FAIL stall_next got=%h want=%h", pc_o, exp_pc); end
        total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL stall_next_reqs got=%0d want=%0d", req_count - r0, nmiss); end
    endtask

    task automatic test_done_hold();
        int r0;
        bit ok;
        block_mem = 1'b1;
        r0 = req_count;
        exp_pc = 32'h200;
        void'(model_fetch(exp_pc));
        do_jump(exp_pc);
        @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            total++; if (mem_inst_req !== 1'b1 || inst_valid_o !== 1'b0 || mem_inst_addr !== 32'h200) begin
                bad++; $display("FAIL done_hold got=%b/%b/%h want=1/0/00000200", mem_inst_req, inst_valid_o, mem_inst_addr);
            end
        end
        block_mem = 1'b0;
        wait_valid(ok);
        total++; if (!ok || pc_o !== 32'h200 || inst_o !== mem_word(32'h200)) begin bad++; $display("FAIL done_hold_out got=%h/%h want=00000200/%h", pc_o, inst_o, mem_word(32'h200)); end
        total++; if (req_count - r0 !== 1) begin bad++; $display("FAIL done_hold_reqs got=%0d want=1", req_count - r0); end
    endtask

    task automatic test_reset_mid_miss();
        int r0, nmiss;
        bit ok;
        do_jump(32'h300);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (inst_valid_o !== 1'b0 || mem_inst_req !== 1'b0) begin bad++; $display("FAIL rmm_reset got=%b/%b want=0/0", inst_valid_o, mem_inst_req); end
        model_clear();
        rst = 1'b0;
        r0 = req_count;
        exp_pc = 32'h0;
        nmiss = model_fetch(exp_pc);
        wait_valid(ok);
        total++; if (!ok || pc_o !== 32'h0 || inst_o !== 32'h0000_0013) begin bad++; $display("FAIL rmm_restart got=%h/%h want=0/00000013", pc_o, inst_o); end
        exp_pc = 32'h300;
        nmiss += model_fetch(exp_pc);
        do_jump(exp_pc);
        wait_valid(ok);
        total++; if (!ok || pc_o !== 32'h300 || inst_o !== mem_word(32'h300)) begin bad++; $display("FAIL rmm_300 got=%h/%h want=00000300/%h", pc_o, inst_o, mem_word(32'h300)); end
        total++; if (req_count - r0 !== nmiss) begin bad++; $display("FAIL rmm_reqs got=%0d want=%0d", req_count - r0, nmiss); end
    endtask

    task automatic test_random();
        int r0, nmiss, act;
        logic [31:0] tgt;
        bit ok;
        for (int it = 0; it < 40; it++) begin
            act = int'($urandom_range(0, 3));
            tgt = 32'($urandom_range(0, 127)) << 2;
            if ($urandom_range(0, 1) == 1) tgt = tgt + 32'h100;
            r0 = req_count;
            nmiss = 0;
            if (act == 0) begin
                exp_pc = tgt;
                nmiss += model_fetch(exp_pc);
                do_jump(exp_pc);
            end else if (act == 1 || act == 2) begin
                exp_pc = exp_pc + 32'h4;
                nmiss += model_fetch(exp_pc);
                do_advance();
            end else begin
                nmiss += model_fetch(exp_pc + 32'h4);
                do_advance();
                repeat ($urandom_range(0, 6)) @(negedge clk);
                exp_pc = tgt;
                nmiss += model_fetch(exp_pc);
                do_jump(exp_pc);
            end
            wait_valid(ok);
            total++; if (!ok || pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
                bad++; $display("FAIL rand_out it=%0d act=%0d got=%h/%h want=%h/%h", it, act, pc_o, inst_o, exp_pc, mem_word(exp_pc));
            end
            total++; if (req_count - r0 !== nmiss) begin
                bad++; $display("FAIL rand_reqs it=%0d act=%0d got=%0d want=%0d", it, act, req_count - r0, nmiss);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        jump_i = 1'b0;
        jump_addr_i = 32'h0;
        id_stall_i = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_jump_hit();
        test_conflict();
        test_jump_in_wait();
        test_stall();
        test_done_hold();
        test_reset_mid_miss();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
